ahb3_boot_copier: RTL



---
 rtl/ahb3_pkg.sv | 25 ++
 rtl/ahb3_boot_copier.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ahb3_pkg.sv
// Shared AHB3 encodings and the boot-copier FSM state type.
// The VR_* states exist only when AHB3_BOOT_COPIER_VERIFY_EN is defined.
package ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_DONE,
    ST_ERROR
`ifdef AHB3_BOOT_COPIER_VERIFY_EN
    , ST_VR_ADDR,
    ST_VR_DATA
`endif
  } copier_state_t;

endpackage

// File: rtl/ahb3_boot_copier.sv
// AHB3 master copying len words from src to dst with single, non-overlapped transfers.
// Define AHB3_BOOT_COPIER_VERIFY_EN to add a read-back compare pass after the copy.
module ahb3_boot_copier
  import ahb3_pkg::*;
#(
  parameter int PLEN = 32,
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [PLEN-1:0] src_addr_i,
  input  logic [PLEN-1:0] dst_addr_i,
  input  logic [CNTW-1:0] len_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            ahb3_hsel_o,
  output logic [PLEN-1:0] ahb3_haddr_o,
  output logic [XLEN-1:0] ahb3_hwdata_o,
  output logic            ahb3_hwrite_o,
  output logic [2:0]      ahb3_hsize_o,
  output logic [2:0]      ahb3_hburst_o,
  output logic [3:0]      ahb3_hprot_o,
  output logic [1:0]      ahb3_htrans_o,
  output logic            ahb3_hmastlock_o,
  input  logic [XLEN-1:0] ahb3_hrdata_i,
  input  logic            ahb3_hready_i,
  input  logic            ahb3_hresp_i
);

  copier_state_t state_reg, state_next;
  logic [PLEN-1:0] src_reg, dst_reg;
  logic [CNTW-1:0] len_reg, idx_reg;
  logic [XLEN-1:0] buf_reg;
`ifdef AHB3_BOOT_COPIER_VERIFY_EN
  logic [XLEN-1:0] vbuf_reg;
  logic            verifying_reg;
`endif

  logic [CNTW-1:0] idx_inc;
  logic [PLEN-1:0] offset;
  logic            last_word, accept, beat;

  assign idx_inc   = idx_reg + 1'b1;
  assign last_word = (idx_inc == len_reg);
  assign offset    = PLEN'({idx_reg, 2'b00});
  assign accept    = start_i && !busy_o;
  // A data phase completes cleanly only when the slave is ready without error
  assign beat      = ahb3_hready_i && !ahb3_hresp_i;

  assign busy_o = !(state_reg == ST_IDLE || state_reg == ST_DONE || state_reg == ST_ERROR);
  assign done_o = (state_reg == ST_DONE);
  assign err_o  = (state_reg == ST_ERROR);

  assign ahb3_hsize_o     = HSIZE_WORD;
  assign ahb3_hburst_o    = HBURST_SINGLE;
  assign ahb3_hprot_o     = HPROT_DATA;
  assign ahb3_hmastlock_o = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      len_reg       <= '0;
      idx_reg       <= '0;
      buf_reg       <= '0;
`ifdef AHB3_BOOT_COPIER_VERIFY_EN
      vbuf_reg      <= '0;
      verifying_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        src_reg <= {src_addr_i[PLEN-1:2], 2'b00};
        dst_reg <= {dst_addr_i[PLEN-1:2], 2'b00};
        len_reg <= len_i;
        idx_reg <= '0;
`ifdef AHB3_BOOT_COPIER_VERIFY_EN
        verifying_reg <= 1'b0;
`endif
      end
`ifdef AHB3_BOOT_COPIER_VERIFY_EN
      // During verify the source read only advances idx; the compare is in the FSM
      if (state_reg == ST_RD_DATA && beat) begin
        if (verifying_reg) idx_reg <= idx_inc;
        else               buf_reg <= ahb3_hrdata_i;
      end
      if (state_reg == ST_WR_DATA && beat) begin
        if (last_word) begin
          idx_reg       <= '0;
          verifying_reg <= 1'b1;
        end else begin
          idx_reg <= idx_inc;
        end
      end
      if (state_reg == ST_VR_DATA && beat) vbuf_reg <= ahb3_hrdata_i;
`else
      if (state_reg == ST_RD_DATA && beat) buf_reg <= ahb3_hrdata_i;
      if (state_reg == ST_WR_DATA && beat) idx_reg <= idx_inc;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    ahb3_hsel_o   = 1'b0;
    ahb3_htrans_o = HTRANS_IDLE;
    ahb3_hwrite_o = 1'b0;
    ahb3_haddr_o  = '0;
    ahb3_hwdata_o = '0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) state_next = (len_i == '0) ? ST_DONE : ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        ahb3_hsel_o   = 1'b1;
        ahb3_htrans_o = HTRANS_NONSEQ;
        ahb3_haddr_o  = src_reg + offset;
        if (ahb3_hready_i) state_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (ahb3_hready_i) begin
          if (ahb3_hresp_i) state_next = ST_ERROR;
`ifdef AHB3_BOOT_COPIER_VERIFY_EN
          else if (verifying_reg) begin
            if (vbuf_reg != ahb3_hrdata_i) state_next = ST_ERROR;
            else if (last_word)            state_next = ST_DONE;
            else                           state_next = ST_VR_ADDR;
          end
`endif
          else state_next = ST_WR_ADDR;
        end
      end
      ST_WR_ADDR: begin
        ahb3_hsel_o   = 1'b1;
        ahb3_htrans_o = HTRANS_NONSEQ;
        ahb3_hwrite_o = 1'b1;
        ahb3_haddr_o  = dst_reg + offset;
        if (ahb3_hready_i) state_next = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        ahb3_hwdata_o = buf_reg;
        if (ahb3_hready_i) begin
          if (ahb3_hresp_i) state_next = ST_ERROR;
`ifdef AHB3_BOOT_COPIER_VERIFY_EN
          else if (last_word) state_next = ST_VR_ADDR;
`else
          else if (last_word) state_next = ST_DONE;
`endif
          else state_next = ST_RD_ADDR;
        end
      end
`ifdef AHB3_BOOT_COPIER_VERIFY_EN
      ST_VR_ADDR: begin
        ahb3_hsel_o   = 1'b1;
        ahb3_htrans_o = HTRANS_NONSEQ;
        ahb3_haddr_o  = dst_reg + offset;
        if (ahb3_hready_i) state_next = ST_VR_DATA;
      end
      ST_VR_DATA: begin
        if (ahb3_hready_i) state_next = ahb3_hresp_i ? ST_ERROR : ST_RD_ADDR;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
